// File: rtl/smem_pkg.sv
// Shared types and defaults for the RC4 S-memory sequencer.
// Phase encoding is visible on the phase output and must stay stable.
package smem_pkg;

  localparam int unsigned DataWidthDef  = 8;
  localparam int unsigned WdogCyclesDef = 4096;

  typedef enum logic [2:0] {
    PhIdle = 3'd0,
    PhRst  = 3'd1,
    PhInit = 3'd2,
    PhKsa  = 3'd3,
    PhPrga = 3'd4,
    PhDone = 3'd5,
    PhErr  = 3'd6
  } phase_e;

  // Watchdog counter is at least 13 bits wide and always wide enough to reach the limit.
  function automatic int unsigned wdog_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles + 1);
    return (w < 13) ? 13 : w;
  endfunction

endpackage

// File: rtl/smem_port_mux.sv
// Combinational 3:1 grant mux for the single S-memory port, keyed by the sequencer phase.
// Only the granted client's request reaches memory; all other write enables are dropped.
module smem_port_mux
  import smem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidthDef
) (
  input  phase_e                phase_i,
  input  logic [DATA_WIDTH-1:0] init_address_i,
  input  logic [DATA_WIDTH-1:0] init_data_i,
  input  logic                  init_wren_i,
  input  logic [DATA_WIDTH-1:0] ksa_address_i,
  input  logic [DATA_WIDTH-1:0] ksa_data_i,
  input  logic                  ksa_wren_i,
  input  logic [DATA_WIDTH-1:0] prga_address_i,
  input  logic [DATA_WIDTH-1:0] prga_data_i,
  input  logic                  prga_wren_i,
  output logic [DATA_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_wren_o
);

  always_comb begin
    mem_address_o = '0;
    mem_data_o    = '0;
    mem_wren_o    = 1'b0;
    case (phase_i)
      PhInit: begin
        mem_address_o = init_address_i;
        mem_data_o    = init_data_i;
        mem_wren_o    = init_wren_i;
      end
      PhKsa: begin
        mem_address_o = ksa_address_i;
        mem_data_o    = ksa_data_i;
        mem_wren_o    = ksa_wren_i;
      end
      PhPrga: begin
        mem_address_o = prga_address_i;
        mem_data_o    = prga_data_i;
        mem_wren_o    = prga_wren_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/smem_sched.sv
// RC4 sequencer: runs init -> KSA -> PRGA clients and owns the single S-memory port.
// Define SMEM_WDOG_EN to enable the per-phase watchdog that can park the sequencer in ERR.
module smem_sched
  import smem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DataWidthDef,
  parameter int unsigned WDOG_CYCLES = WdogCyclesDef
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            phase,
  output logic                  sub_rst,
  output logic                  init_start,
  output logic                  ksa_start,
  output logic                  prga_start,
  input  logic                  init_finish,
  input  logic                  ksa_finish,
  input  logic                  prga_finish,
  input  logic [DATA_WIDTH-1:0] init_address,
  input  logic [DATA_WIDTH-1:0] init_data,
  input  logic                  init_wren,
  input  logic [DATA_WIDTH-1:0] ksa_address,
  input  logic [DATA_WIDTH-1:0] ksa_data,
  input  logic                  ksa_wren,
  input  logic [DATA_WIDTH-1:0] prga_address,
  input  logic [DATA_WIDTH-1:0] prga_data,
  input  logic                  prga_wren,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [DATA_WIDTH-1:0] q
);

  phase_e     state_q, state_d;
  logic [2:0] start_q, start_d;
  logic       wdog_trip;

`ifdef SMEM_WDOG_EN
  localparam int unsigned WdogW = wdog_width(WDOG_CYCLES);

  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             running;

  assign running   = (state_q == PhInit) || (state_q == PhKsa) || (state_q == PhPrga);
  // Trips in the last allowed cycle so a phase gets exactly WDOG_CYCLES cycles.
  assign wdog_trip = running && (wdog_q >= WdogW'(WDOG_CYCLES - 1));

  always_comb begin
    wdog_d = wdog_q;
    if (state_d != state_q) begin
      wdog_d = '0;
    end else if (running) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
  assign wdog_trip   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PhIdle;
      start_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PhIdle, PhDone, PhErr: if (start) state_d = PhRst;
      PhRst:  state_d = PhInit;
      PhInit: begin
        if (init_finish)    state_d = PhKsa;
        else if (wdog_trip) state_d = PhErr;
      end
      PhKsa: begin
        if (ksa_finish)     state_d = PhPrga;
        else if (wdog_trip) state_d = PhErr;
      end
      PhPrga: begin
        if (prga_finish)    state_d = PhDone;
        else if (wdog_trip) state_d = PhErr;
      end
      default: state_d = PhIdle;
    endcase
    // Registered pulses land in the first cycle of the phase being entered.
    start_d[0] = (state_d == PhInit) && (state_q != PhInit);
    start_d[1] = (state_d == PhKsa)  && (state_q != PhKsa);
    start_d[2] = (state_d == PhPrga) && (state_q != PhPrga);
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    error   = 1'b0;
    sub_rst = 1'b0;
    unique case (state_q)
      PhIdle: sub_rst = 1'b1;
      PhRst: begin
        sub_rst = 1'b1;
        busy    = 1'b1;
      end
      PhInit, PhKsa, PhPrga: busy = 1'b1;
      PhDone: done = 1'b1;
      PhErr: begin
        sub_rst = 1'b1;
`ifdef SMEM_WDOG_EN
        error   = 1'b1;
`endif
      end
      default: sub_rst = 1'b1;
    endcase
  end

  assign phase      = state_q;
  assign init_start = start_q[0];
  assign ksa_start  = start_q[1];
  assign prga_start = start_q[2];
  assign q          = mem_q;

  smem_port_mux #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_port_mux (
    .phase_i        (state_q),
    .init_address_i (init_address),
    .init_data_i    (init_data),
    .init_wren_i    (init_wren),
    .ksa_address_i  (ksa_address),
    .ksa_data_i     (ksa_data),
    .ksa_wren_i     (ksa_wren),
    .prga_address_i (prga_address),
    .prga_data_i    (prga_data),
    .prga_wren_i    (prga_wren),
    .mem_address_o  (mem_address),
    .mem_data_o     (mem_data),
    .mem_wren_o     (mem_wren)
  );

endmodule

// File: tb/tb_smem_sched.sv
// Scoreboard bench for smem_sched: phase-transition records and memory-port snapshots are
// queued by the stimulus and checked by an independent monitor on the falling clock edge.
module tb_smem_sched;

`ifdef SMEM_WDOG_EN
  localparam int unsigned WDOG = 16;
  localparam int LAT_I = 5, LAT_K = 9, LAT_P = 7;
`else
  localparam int unsigned WDOG = 4096;
  localparam int LAT_I = 257, LAT_K = 770, LAT_P = 300;
`endif

  logic       clk = 1'b0;
  logic       rst, start;
  logic       busy, done, error, sub_rst;
  logic [2:0] phase;
  logic       init_start, ksa_start, prga_start;
  logic       init_finish, ksa_finish, prga_finish;
  logic [7:0] init_address, init_data, ksa_address, ksa_data, prga_address, prga_data;
  logic       init_wren, ksa_wren, prga_wren;
  logic [7:0] mem_address, mem_data, mem_q, q;
  logic       mem_wren;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  smem_sched #(
    .DATA_WIDTH  (8),
    .WDOG_CYCLES (WDOG)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .phase        (phase),
    .sub_rst      (sub_rst),
    .init_start   (init_start),
    .ksa_start    (ksa_start),
    .prga_start   (prga_start),
    .init_finish  (init_finish),
    .ksa_finish   (ksa_finish),
    .prga_finish  (prga_finish),
    .init_address (init_address),
    .init_data    (init_data),
    .init_wren    (init_wren),
    .ksa_address  (ksa_address),
    .ksa_data     (ksa_data),
    .ksa_wren     (ksa_wren),
    .prga_address (prga_address),
    .prga_data    (prga_data),
    .prga_wren    (prga_wren),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .mem_wren     (mem_wren),
    .mem_q        (mem_q),
    .q            (q)
  );

  // Client models: count after their start pulse, raise a sticky finish, clear on sub_rst.
  logic [2:0] fin = 3'b000;
  logic [2:0] on  = 3'b000;
  int         cnt [3];
  int         lat [3];
  bit         ksa_stuck = 1'b0;
  logic [2:0] stp;

  assign stp         = {prga_start, ksa_start, init_start};
  assign init_finish = fin[0];
  assign ksa_finish  = fin[1];
  assign prga_finish = fin[2];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (sub_rst) begin
        fin[k] <= 1'b0;
        on[k]  <= 1'b0;
        cnt[k] <= 0;
      end else begin
        if (stp[k]) on[k] <= 1'b1;
        if (on[k] && !fin[k]) begin
          cnt[k] <= cnt[k] + 1;
          if (cnt[k] == lat[k] - 1 && !(k == 1 && ksa_stuck)) fin[k] <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Observation record: {phase, sub_rst, busy, done, error, prga_start, ksa_start, init_start}
  function automatic logic [9:0] obs(input logic [2:0] ph, input logic sr, input logic bz,
                                     input logic dn, input logic er, input logic [2:0] st);
    return {ph, sr, bz, dn, er, st};
  endfunction

  logic [9:0]  exp_q  [$];
  logic [16:0] mexp_q [$];
  logic [2:0]  last_ph = 3'd0;
  int          pc [3] = '{0, 0, 0};

  always @(negedge clk) begin
    logic [9:0]  o, e;
    logic [16:0] m;
    o = obs(phase, sub_rst, busy, done, error, stp);
    if (rst) begin
      last_ph <= phase;
    end else if (phase !== last_ph) begin
      last_ph <= phase;
      if (exp_q.size() == 0) begin
        chk("unexpected_phase", {22'd0, o}, 32'h3ff);
      end else begin
        e = exp_q.pop_front();
        chk("phase_seq", {22'd0, o}, {22'd0, e});
      end
    end
    if (mexp_q.size() > 0) begin
      m = mexp_q.pop_front();
      chk("mem_port", {15'd0, mem_address, mem_data, mem_wren}, {15'd0, m});
    end
    for (int k = 0; k < 3; k++) pc[k] <= pc[k] + int'(stp[k]);
  end

  task automatic push_run();
    exp_q.push_back(obs(3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000));
    exp_q.push_back(obs(3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001));
    exp_q.push_back(obs(3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010));
    exp_q.push_back(obs(3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100));
    exp_q.push_back(obs(3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000));
  endtask

  task automatic pulse_start();
    @(posedge clk) #1 start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
  endtask

  task automatic wait_ph(input logic [2:0] p, input int lim);
    int n = 0;
    while (phase !== p && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("reach_phase", {29'd0, phase}, {29'd0, p});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int base [3];
    int n;
    lat[0] = LAT_I; lat[1] = LAT_K; lat[2] = LAT_P;
    rst = 1'b1; start = 1'b0; mem_q = 8'hC3;
    init_address = 8'h11; init_data = 8'h21; init_wren = 1'b1;
    ksa_address  = 8'h3C; ksa_data  = 8'h5A; ksa_wren  = 1'b0;
    prga_address = 8'h77; prga_data = 8'h88; prga_wren = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_phase", {29'd0, phase}, 32'd0);
    chk("rst_flags", {27'd0, busy, done, error, sub_rst, mem_wren}, 32'b00010);
    chk("rst_starts", {29'd0, stp}, 32'd0);
    chk("rst_mem", {16'd0, mem_address, mem_data}, 32'd0);
    chk("q_pass", {24'd0, q}, 32'hC3);
    mem_q = 8'h5E;
    #1 chk("q_pass2", {24'd0, q}, 32'h5E);
    @(negedge clk) rst = 1'b0;

    // Run 1: full sequence with grant checks in each phase
    base = pc;
    push_run();
    pulse_start();
    wait_ph(3'd2, 10);
    #1 mexp_q.push_back({8'h11, 8'h21, 1'b1});
    wait_ph(3'd3, 2000);
    #1 init_address = 8'hAA;
    mexp_q.push_back({8'h3C, 8'h5A, 1'b0});
    @(negedge clk) #1 ksa_wren = 1'b1;
    mexp_q.push_back({8'h3C, 8'h5A, 1'b1});
    start = 1'b1;
    @(negedge clk) #1 start = 1'b0;
    ksa_wren = 1'b0; init_address = 8'h11;
    repeat (3) @(negedge clk);
    chk("start_ignored_ksa", {29'd0, phase}, 32'd3);
    wait_ph(3'd4, 2000);
    #1 mexp_q.push_back({8'h77, 8'h88, 1'b1});
    n = 0;
    while (!prga_finish && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("done_after_finish", {31'd0, done}, 32'd1);
    #1 mexp_q.push_back({8'h00, 8'h00, 1'b0});
    @(negedge clk);
    chk("sticky_before", {29'd0, fin}, 32'b111);
    chk("init_pulse_cnt", pc[0] - base[0], 32'd1);
    chk("ksa_pulse_cnt", pc[1] - base[1], 32'd1);
    chk("prga_pulse_cnt", pc[2] - base[2], 32'd1);
    chk("run1_drained", exp_q.size(), 32'd0);

    // Run 2: restart from DONE, then async reset mid-INIT
    base = pc;
    push_run();
    pulse_start();
    wait_ph(3'd2, 10);
    chk("sticky_cleared", {29'd0, fin}, 32'd0);
    @(negedge clk) #2;
    chk("init_grant_wren", {31'd0, mem_wren}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_wren", {31'd0, mem_wren}, 32'd0);
    chk("async_state", {28'd0, phase, sub_rst}, 32'b0001);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    chk("run2_init_pulse", pc[0] - base[0], 32'd1);
    chk("run2_ksa_pulse", pc[1] - base[1], 32'd0);

`ifdef SMEM_WDOG_EN
    // Watchdog: KSA never finishes
    ksa_stuck = 1'b1;
    exp_q.push_back(obs(3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000));
    exp_q.push_back(obs(3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001));
    exp_q.push_back(obs(3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010));
    exp_q.push_back(obs(3'd6, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000));
    pulse_start();
    wait_ph(3'd3, 100);
    ksa_wren = 1'b1;
    n = 0;
    while (phase === 3'd3 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("wdog_ksa_cycles", n, 32'd16);
    chk("wdog_error", {31'd0, error}, 32'd1);
    #1 mexp_q.push_back({8'h00, 8'h00, 1'b0});
    @(negedge clk);
    ksa_wren = 1'b0;
    ksa_stuck = 1'b0;
    push_run();
    pulse_start();
    wait_ph(3'd5, 200);
`endif

    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size() + mexp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/smem_sched.md
Name: smem_sched

Overview:
- Top-level sequencer for the RC4 datapath.
- Owns the single-port S-memory (256 x 8) and runs three client engines in order: memory init (s[i]=i), KSA shuffle, then PRGA/decrypt.
- Issues one-cycle start pulses, waits for each client's level finish, and time-multiplexes the memory port so only the granted client can write.

Parameters:
- DATA_WIDTH, 8, width of S-memory address and data.
- WDOG_CYCLES, 4096, per-phase cycle limit; used only when SMEM_WDOG_EN is defined.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  request full init->ksa->prga run; sampled in IDLE, DONE and ERR
- busy  out  1  high while any phase is running
- done  out  1  high in DONE until next start or rst
- error  out  1  watchdog trip (held low if SMEM_WDOG_EN undefined)
- phase  out  3  encoded state: IDLE=0, RST=1, INIT=2, KSA=3, PRGA=4, DONE=5, ERR=6
- sub_rst  out  1  synchronous reset to all three clients
- init_start, ksa_start, prga_start  out  1 each  one-cycle start pulses
- init_finish, ksa_finish, prga_finish  in  1 each  level finish from clients, sticky until sub_rst
- init_address/init_data, ksa_address/ksa_data, prga_address/prga_data  in  DATA_WIDTH each  client memory request
- init_wren, ksa_wren, prga_wren  in  1 each  client write enables
- mem_address  out  DATA_WIDTH  to S-memory
- mem_data  out  DATA_WIDTH  to S-memory
- mem_wren  out  1  to S-memory
- mem_q  in  DATA_WIDTH  from S-memory
- q  out  DATA_WIDTH  mem_q fanned out to all clients unchanged (combinational)

Behaviour:
- Reset (async): state=IDLE, busy=0, done=0, error=0, sub_rst=1, all *_start=0, mem_wren=0, mem_address=0, mem_data=0.
- IDLE:
  - sub_rst=1.
  - start=1 -> RST.
- RST:
  - Lasts exactly 1 cycle; sub_rst=1, clearing stale client finish flags.
  - Then -> INIT, with init_start=1 in the first INIT cycle only.
- INIT:
  - Grant init port.
  - First cycle with init_finish=1 -> KSA; ksa_start=1 in the first KSA cycle.
  - init_finish already high on entry is impossible after RST; if seen anyway, still advance.
- KSA:
  - Grant ksa port.
  - ksa_finish=1 -> PRGA; prga_start=1 in the first PRGA cycle.
- PRGA:
  - Grant prga port.
  - prga_finish=1 -> DONE.
- DONE:
  - done=1, busy=0.
  - start=1 -> RST; a restart always re-inits memory.
- ERR:
  - error=1, busy=0.
  - start=1 -> RST, which clears error.
- Start pulses are registered outputs, exactly one cycle wide, asserted in the first cycle of the phase.
- sub_rst is low in INIT, KSA, PRGA and DONE.
- busy=1 in RST, INIT, KSA and PRGA.
- start is ignored while busy.
- Memory mux:
  - Combinational from the state register, so zero added latency.
  - The granted client's address, data and wren pass through.
  - Non-granted wren inputs are ignored.
  - In IDLE, RST, DONE and ERR: mem_wren=0, mem_address=0, mem_data=0.
- Phase hand-off: no cycle in which two clients are granted. The last cycle of phase N grants N; the next cycle grants N+1.
- rst asserted mid-phase: immediate return to IDLE, and mem_wren drops asynchronously.

Optional Feature:
- SMEM_WDOG_EN defined:
  - A 13-bit-minimum cycle counter clears on each phase entry and increments each cycle in INIT, KSA and PRGA.
  - Reaching WDOG_CYCLES with the finish still low -> ERR.
- SMEM_WDOG_EN undefined: no counter, error tied 0, ERR unreachable.

Decomposition:
- Package smem_pkg:
  - phase enum with the encodings above.
  - DATA_WIDTH default.
  - WDOG_CYCLES default.
- Sub-module smem_port_mux: purely combinational 3:1 grant mux with wren gating, keyed by phase.
- Sequencer FSM and watchdog stay in smem_sched.

Test Plan:
- Reset, then start=1 for 1 cycle. Client models finish after 257/770/300 cycles -> phase goes 1,2,3,4,5; each *_start high exactly 1 cycle; done=1 at the cycle after prga_finish.
- During KSA, drive init_wren=1, init_address=8'hAA and prga_wren=1 -> mem_wren follows ksa_wren only; mem_address=ksa_address.
- Second start in DONE -> sub_rst=1 for 1 cycle, init_start pulses, done=0, busy=1; sticky finishes from the previous run are cleared.
- start=1 while in KSA -> ignored: no extra pulses, phase stays 3.
- Assert rst asynchronously mid-INIT with init_wren=1 -> mem_wren=0 before the next clk edge; phase=0, sub_rst=1.
- SMEM_WDOG_EN with WDOG_CYCLES=16 and ksa_finish stuck low -> ERR after 16 KSA cycles, error=1, mem_wren=0; then start -> RST and error=0.
